// File: rtl/mdu_seq.sv
// mdu_seq: sequential multiply/divide unit with HI/LO registers.
// MUL takes 5 busy cycles and DIV takes 10; the result is written from the latched operands on the last busy edge.
module mdu_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [3:0]  MDUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        D_IsMDU,
  output logic        Busy,
  output logic        Stall,
  output logic [31:0] MDURes
);
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d, a_q, a_d, b_q, b_d;
  logic sgn_q, sgn_d;
  logic [63:0] prod;
  logic [31:0] da, db, uq, ur, quo, rem;
  // Signed division works on magnitudes; 0x80000000 / -1 then yields 0x80000000 rem 0 naturally.
  always_comb begin
    prod = {{32{sgn_q & a_q[31]}}, a_q} * {{32{sgn_q & b_q[31]}}, b_q};
    da = (sgn_q & a_q[31]) ? -a_q : a_q;
    db = (sgn_q & b_q[31]) ? -b_q : b_q;
    uq = (db == 32'd0) ? 32'd0 : da / db;
    ur = (db == 32'd0) ? 32'd0 : da % db;
    quo = (sgn_q & (a_q[31] ^ b_q[31])) ? -uq : uq;
    rem = (sgn_q & a_q[31]) ? -ur : ur;
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    hi_d = hi_q;
    lo_d = lo_q;
    a_d = a_q;
    b_d = b_q;
    sgn_d = sgn_q;
    if (state_q == IDLE) begin
      if (Start && MDUOp < 4'd4) begin
        a_d = A;
        b_d = B;
        sgn_d = ~MDUOp[0];
        cnt_d = MDUOp[1] ? 4'd10 : 4'd5;
        state_d = MDUOp[1] ? DIV : MUL;
      end
      if (Start && MDUOp == 4'd4) hi_d = A;
      if (Start && MDUOp == 4'd5) lo_d = A;
    end else begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        state_d = IDLE;
        if (state_q == MUL) begin
          hi_d = prod[63:32];
          lo_d = prod[31:0];
        end else if (b_q != 32'd0) begin
          hi_d = rem;
          lo_d = quo;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q <= 4'd0;
      hi_q <= 32'd0;
      lo_q <= 32'd0;
      a_q <= 32'd0;
      b_q <= 32'd0;
      sgn_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      a_q <= a_d;
      b_q <= b_d;
      sgn_q <= sgn_d;
    end
  end
  assign Busy = reset & (state_q != IDLE);
  assign Stall = reset & D_IsMDU & (Busy | (Start & (MDUOp < 4'd4)));
  assign MDURes = !reset ? 32'd0 : (MDUOp == 4'd6) ? hi_q : (MDUOp == 4'd7) ? lo_q : 32'd0;
endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: directed and random stimulus against a cycle-level arithmetic model of mdu_seq.
module tb_mdu_seq;
  logic clk = 0, reset, Start, D_IsMDU, Busy, Stall;
  logic [3:0] MDUOp;
  logic [31:0] A, B, MDURes;
  int n_chk = 0, n_fail = 0;
  logic en = 0;
  int m_rem = 0;
  logic [31:0] m_hi = 0, m_lo = 0, pa, pb;
  logic [3:0] pop;
  longint p, sq, sr;
  logic [63:0] pu;

  mdu_seq dut (.clk(clk), .reset(reset), .Start(Start), .MDUOp(MDUOp), .A(A), .B(B),
               .D_IsMDU(D_IsMDU), .Busy(Busy), .Stall(Stall), .MDURes(MDURes));

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference: a pending operation finishes after a fixed number of busy cycles.
  always @(posedge clk) begin
    if (!reset) begin
      m_hi = 0; m_lo = 0; m_rem = 0;
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) begin
        case (pop)
          4'd0: begin p = longint'($signed(pa)) * longint'($signed(pb)); m_hi = p[63:32]; m_lo = p[31:0]; end
          4'd1: begin pu = {32'b0, pa} * {32'b0, pb}; m_hi = pu[63:32]; m_lo = pu[31:0]; end
          4'd2: if (pb != 0) begin
            sq = longint'($signed(pa)) / longint'($signed(pb));
            sr = longint'($signed(pa)) % longint'($signed(pb));
            m_lo = sq[31:0]; m_hi = sr[31:0];
          end
          default: if (pb != 0) begin m_lo = pa / pb; m_hi = pa % pb; end
        endcase
      end
    end else if (Start) begin
      if (MDUOp <= 4'd3) begin pop = MDUOp; pa = A; pb = B; m_rem = (MDUOp <= 4'd1) ? 5 : 10; end
      else if (MDUOp == 4'd4) m_hi = A;
      else if (MDUOp == 4'd5) m_lo = A;
    end
  end

  always @(negedge clk) if (en) begin
    logic eb;
    eb = reset && m_rem > 0;
    check("busy", {31'b0, Busy}, {31'b0, eb});
    check("stall", {31'b0, Stall}, {31'b0, reset && D_IsMDU && (eb || (Start && MDUOp <= 4'd3))});
    check("mdures", MDURes, !reset ? 32'd0 : MDUOp == 4'd6 ? m_hi : MDUOp == 4'd7 ? m_lo : 32'd0);
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic rd(input string nm, input logic [3:0] o, input logic [31:0] exp);
    MDUOp = o; #1;
    check(nm, MDURes, exp);
    check({nm, "_model"}, (o == 4'd6) ? m_hi : m_lo, exp);
  endtask

  task automatic wait_idle(input string nm, input int exp_n);
    int n = 0;
    while (Busy && n < 30) begin
      step(); n++;
      A = $urandom; B = $urandom;
    end
    check(nm, 32'(n), 32'(exp_n));
  endtask

  task automatic run(input string nm, input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input int exp_n);
    Start = 1; MDUOp = o; A = a; B = b;
    step();
    Start = 0; MDUOp = 4'd8; A = $urandom; B = $urandom;
    wait_idle(nm, exp_n);
  endtask

  initial begin
    reset = 0; Start = 0; MDUOp = 4'd8; A = 0; B = 0; D_IsMDU = 0;
    repeat (2) step();
    en = 1; reset = 1;
    check("reset_busy", {31'b0, Busy}, 32'd0);
    rd("reset_hi", 4'd6, 32'd0);
    rd("reset_lo", 4'd7, 32'd0);
    run("mult_cycles", 4'd0, 32'hFFFFFFFE, 32'd3, 5);
    rd("mult_hi", 4'd6, 32'hFFFFFFFF);
    rd("mult_lo", 4'd7, 32'hFFFFFFFA);
    run("multu_cycles", 4'd1, 32'hFFFFFFFF, 32'd2, 5);
    rd("multu_hi", 4'd6, 32'h00000001);
    rd("multu_lo", 4'd7, 32'hFFFFFFFE);
    D_IsMDU = 1; Start = 1; MDUOp = 4'd2; A = 32'hFFFFFFF9; B = 32'd2; #1;
    check("div_start_stall", {31'b0, Stall}, 32'd1);
    run("div_cycles", 4'd2, 32'hFFFFFFF9, 32'd2, 10);
    D_IsMDU = 0;
    rd("div_lo", 4'd7, 32'hFFFFFFFD);
    rd("div_hi", 4'd6, 32'hFFFFFFFF);
    run("divu0_cycles", 4'd3, 32'd7, 32'd0, 10);
    rd("divu0_hi", 4'd6, 32'hFFFFFFFF);
    rd("divu0_lo", 4'd7, 32'hFFFFFFFD);
    run("divovf_cycles", 4'd2, 32'h80000000, 32'hFFFFFFFF, 10);
    rd("divovf_lo", 4'd7, 32'h80000000);
    rd("divovf_hi", 4'd6, 32'h00000000);
    Start = 1; MDUOp = 4'd2; A = 32'd100; B = 32'd7;
    step();
    Start = 0; MDUOp = 4'd8;
    repeat (2) step();
    Start = 1; MDUOp = 4'd0; A = 32'd5; B = 32'd5;
    step();
    Start = 0; MDUOp = 4'd8;
    wait_idle("ignored_start_cycles", 7);
    rd("ignored_lo", 4'd7, 32'd14);
    rd("ignored_hi", 4'd6, 32'd2);
    D_IsMDU = 1; Start = 1; MDUOp = 4'd5; A = 32'h1234; #1;
    check("mtlo_stall", {31'b0, Stall}, 32'd0);
    step();
    Start = 0;
    rd("mflo", 4'd7, 32'h1234);
    check("mflo_stall", {31'b0, Stall}, 32'd0);
    D_IsMDU = 0;
    Start = 1; MDUOp = 4'd2; A = 32'd100; B = 32'd7;
    step();
    Start = 0; MDUOp = 4'd8;
    repeat (3) step();
    reset = 0;
    step();
    reset = 1;
    check("abort_busy", {31'b0, Busy}, 32'd0);
    rd("abort_hi", 4'd6, 32'd0);
    rd("abort_lo", 4'd7, 32'd0);
    run("mult23_cycles", 4'd0, 32'd2, 32'd3, 5);
    rd("mult23_lo", 4'd7, 32'd6);
    rd("mult23_hi", 4'd6, 32'd0);
    for (int i = 0; i < 600; i++) begin
      Start = 1'($urandom_range(0, 1));
      MDUOp = 4'($urandom_range(0, 9));
      A = ($urandom_range(0, 9) == 0) ? 32'h80000000 : $urandom;
      B = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom_range(0, 9) == 0) ? 32'hFFFFFFFF : $urandom;
      D_IsMDU = 1'($urandom_range(0, 1));
      reset = ($urandom_range(0, 59) != 0);
      step();
    end
    reset = 1; Start = 0;
    repeat (12) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
